aes_key_expand: RTL and testbench
=================================

Name: aes_key_expand

Overview:
Sequential AES key-schedule engine that supports 128-, 192- and 256-bit keys. It generates one 32-bit schedule word per cycle and emits 128-bit round keys over a valid/ready interface. It is the parametrised successor to the combinational single-round g-function. It reuses four instances of the existing s_box. The round constant comes from a running GF(2^8) xtime register, not a round-indexed table. It sits between the key register file and the round pipeline, and it stalls on back-pressure.

Parameters:
ENABLE_192, 1, when 0 the key_len value 2'b01 is reserved
ENABLE_256, 1, when 0 the key_len value 2'b10 is reserved

Ports:
clk  in  1  clock; everything is on the rising edge
rst  in  1  synchronous, active-high reset
start  in  1  request a new expansion; sampled only in IDLE
key_len  in  2  00=128 (Nk=4, Nr=10), 01=192 (Nk=6, Nr=12), 10=256 (Nk=8, Nr=14), 11=reserved
key_in  in  256  cipher key, word 0 = [255:224]; 128-bit keys use [255:128]; 192-bit keys use [255:64]
rk_out  out  128  round key, word 4k in [127:96]
rk_idx  out  4  round index k of rk_out
rk_valid  out  1  rk_out holds an unconsumed round key
rk_ready  in  1  consumer accepts rk_out when rk_valid && rk_ready
rk_last  out  1  rk_out is round key Nr; qualified by rk_valid
busy  out  1  the engine is in RUN or DRAIN
done  out  1  one-cycle pulse after the final handshake

Behaviour:
- Reset values: rk_out=0, rk_idx=0, rk_valid=0, rk_last=0, busy=0, done=0, state=IDLE.
- rst is synchronous. It aborts any run mid-operation, discards any pending key, and returns the engine to IDLE on the next edge.
- States: IDLE -> RUN -> DRAIN -> IDLE.
- IDLE, start=1, key_len legal:
  - latch key_in and Nk;
  - set word counter i=0, Nk-phase counter j=0, rcon=8'h01;
  - go to RUN; busy=1 from the next cycle.
- IDLE, start=1, key_len reserved (11, or disabled by parameter): ignored, stay in IDLE.
- start while not IDLE: ignored.
- RUN, one word w[i] per unstalled cycle:
  - i<Nk: w[i] = latched key word i.
  - i>=Nk, j==0: w[i] = w[i-Nk] ^ (SubWord(RotWord(w[i-1])) ^ {rcon,24'h0}). Then rcon <= xtime(rcon) = {rcon[6:0],1'b0} ^ (rcon[7] ? 8'h1B : 8'h00).
  - i>=Nk, Nk==8, j==4: w[i] = w[i-Nk] ^ SubWord(w[i-1]).
  - all other i>=Nk: w[i] = w[i-Nk] ^ w[i-1].
  - RotWord is a left rotate by one byte.
  - j wraps from Nk-1 to 0. Do not use a divider.
- Word window: an 8-entry shift register of the last words produced. w[i-1] is entry 0 and w[i-Nk] is entry Nk-1.
- Accumulator:
  - each produced word shifts into a 3-word group buffer;
  - when i[1:0]==3, rk_out <= {group, w[i]}, rk_idx <= i>>2, rk_valid <= 1, rk_last <= (i == 4*Nr+3).
- Stall: word production is frozen (i, j, rcon, window and group all hold) in any cycle where i[1:0]==3 && rk_valid && !rk_ready.
- Handshake and load in the same cycle: the new round key loads, and rk_valid stays 1 with no bubble.
- A handshake with no new load clears rk_valid.
- rk_out, rk_idx and rk_last are stable while rk_valid && !rk_ready.
- End of RUN: after w[4*Nr+3] is produced, go to DRAIN.
- DRAIN:
  - wait for the handshake of the last round key;
  - on that edge: rk_valid=0, busy=0, done=1 for one cycle, state=IDLE.
- Latency with rk_ready held at 1:
  - rk_valid rises 4 cycles after the start edge;
  - a new round key follows every 4 cycles;
  - totals are 44/52/60 word cycles for 128/192/256 keys.
- rcon across a full run:
  - 10 uses (01..36) for 128;
  - 8 uses (01..80) for 192;
  - 7 uses (01..40) for 256.

Test Plan:
- 128-bit key 2b7e1516_28aed2a6_abf71588_09cf4f3c, rk_ready=1:
  - 11 keys, rk_idx 0..10;
  - rk1 = a0fafe17_88542cb1_23a33939_2a6c7605;
  - rk10 = d014f9a8_c9ee2589_e13f0cc8_b6630ca6 with rk_last=1;
  - done pulse follows.
- 192-bit key 8e73b0f7_da0e6452_c810f32b_809079e5_62f8ead2_522c6b7b:
  - 13 keys;
  - rk12 = e98ba06f_448c773c_8ecc7204_01002202.
- 256-bit key 603deb10_15ca71be_2b73aef0_857d7781_1f352c07_3b6108d7_2d9810a3_0914dff4:
  - 15 keys;
  - rk1 = 1f352c07_3b6108d7_2d9810a3_0914dff4;
  - rk14 = fe4890d1_e6188d0b_046df344_706c631e.
- Random rk_ready back-pressure (on 128, 192 and 256 runs):
  - the same key sequence as above;
  - rk_out is stable while stalled;
  - no key is dropped or duplicated;
  - exactly one done pulse.
- key_len=11, or key_len=01 with ENABLE_192=0: start is ignored; busy and rk_valid stay 0.
- rst asserted at the rk_idx=5 handshake:
  - next cycle: rk_valid=0, busy=0, IDLE;
  - a fresh 128-bit start reproduces rk0..rk10 exactly.

Source files
------------

// File: rtl/aes_key_expand.sv
// AES key-schedule engine for 128/192/256-bit keys.
// Produces one 32-bit schedule word per cycle and packs every four words
// into a 128-bit round key offered on a valid/ready port. The round
// constant is kept as a running xtime register rather than a table.
//
// state | meaning
// ------+-------------------------------------------------------------
// IDLE  | waiting for start with a legal key_len
// RUN   | producing schedule words, one per unstalled cycle
// DRAIN | last round key loaded, waiting for its handshake

module s_box (
    input  logic [7:0] a,
    output logic [7:0] y
);
    // Forward AES S-box, byte 0x00 in the top byte of the table.
    localparam logic [2047:0] SBOX_TBL = {
        128'h637c777bf26b6fc53001672bfed7ab76,
        128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115,
        128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84,
        128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8,
        128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973,
        128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479,
        128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
        128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df,
        128'h8ca1890dbfe6426841992d0fb054bb16
    };

    // Byte a lives at bit 8*(255-a)+7 downwards, i.e. index {~a, 3'b111}.
    assign y = SBOX_TBL[{~a, 3'b111} -: 8];
endmodule

module aes_key_expand #(
    parameter bit ENABLE_192 = 1'b1,
    parameter bit ENABLE_256 = 1'b1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic [1:0]   key_len,
    input  logic [255:0] key_in,
    output logic [127:0] rk_out,
    output logic [3:0]   rk_idx,
    output logic         rk_valid,
    input  logic         rk_ready,
    output logic         rk_last,
    output logic         busy,
    output logic         done
);
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } state_t;

    state_t       state;
    state_t       state_nxt;

    logic [31:0]  key_w [8];
    logic [31:0]  win   [8];
    logic [95:0]  grp;

    logic [3:0]   nk;
    logic [5:0]   last_i;
    logic [5:0]   wi;
    logic [2:0]   ph;
    logic [7:0]   rcon;

    logic [3:0]   nk_sel;
    logic [5:0]   last_sel;
    logic         len_ok;
    logic         start_ok;
    logic         stall;
    logic         advance;
    logic         load;
    logic         hs;
    logic         last_word;
    logic         past_key;
    logic [2:0]   back_sel;
    logic [2:0]   ph_wrap;
    logic [31:0]  w_prev;
    logic [31:0]  w_back;
    logic [31:0]  key_word;
    logic [31:0]  sub_in;
    logic [31:0]  sub_out;
    logic [31:0]  w_new;
    logic [7:0]   rcon_nxt;

    // Decode key length into Nk, the index of the final word, and legality.
    always_comb begin
        len_ok   = 1'b0;
        nk_sel   = 4'd4;
        last_sel = 6'd43;
        case (key_len)
            2'b00: begin
                len_ok   = 1'b1;
                nk_sel   = 4'd4;
                last_sel = 6'd43;
            end
            2'b01: begin
                len_ok   = ENABLE_192;
                nk_sel   = 4'd6;
                last_sel = 6'd51;
            end
            2'b10: begin
                len_ok   = ENABLE_256;
                nk_sel   = 4'd8;
                last_sel = 6'd59;
            end
            default: begin
                len_ok   = 1'b0;
                nk_sel   = 4'd4;
                last_sel = 6'd43;
            end
        endcase
    end

    assign start_ok  = (state == IDLE) && start && len_ok;
    assign hs        = rk_valid && rk_ready;
    // Only the word that completes a group can collide with an unconsumed key.
    assign stall     = (wi[1:0] == 2'b11) && rk_valid && !rk_ready;
    assign advance   = (state == RUN) && !stall;
    assign load      = advance && (wi[1:0] == 2'b11);
    assign last_word = (wi == last_i);
    assign past_key  = (wi >= {2'b00, nk});

    assign back_sel  = 3'(nk - 4'd1);
    assign ph_wrap   = 3'(nk - 4'd1);
    assign w_prev    = win[0];
    assign w_back    = win[back_sel];
    assign key_word  = key_w[wi[2:0]];
    assign sub_in    = (ph == 3'd0) ? {w_prev[23:0], w_prev[31:24]} : w_prev;
    assign rcon_nxt  = {rcon[6:0], 1'b0} ^ (rcon[7] ? 8'h1b : 8'h00);

    s_box u_sbox_3 (.a(sub_in[31:24]), .y(sub_out[31:24]));
    s_box u_sbox_2 (.a(sub_in[23:16]), .y(sub_out[23:16]));
    s_box u_sbox_1 (.a(sub_in[15:8]),  .y(sub_out[15:8]));
    s_box u_sbox_0 (.a(sub_in[7:0]),   .y(sub_out[7:0]));

    // Schedule word for the current index: key copy, then the three recurrence forms.
    always_comb begin
        w_new = key_word;
        if (past_key) begin
            if (ph == 3'd0) begin
                w_new = w_back ^ sub_out ^ {rcon, 24'h0};
            end else if ((nk == 4'd8) && (ph == 3'd4)) begin
                w_new = w_back ^ sub_out;
            end else begin
                w_new = w_back ^ w_prev;
            end
        end
    end

    // FSM state register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // FSM next-state logic.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start_ok)              state_nxt = RUN;
            RUN:     if (advance && last_word)  state_nxt = DRAIN;
            DRAIN:   if (hs)                    state_nxt = IDLE;
            default:                            state_nxt = IDLE;
        endcase
    end

    // FSM outputs.
    always_comb begin
        busy = 1'b0;
        case (state)
            RUN:     busy = 1'b1;
            DRAIN:   busy = 1'b1;
            default: busy = 1'b0;
        endcase
    end

    // Word counter, Nk-phase counter and running round constant.
    always_ff @(posedge clk) begin
        if (rst) begin
            nk     <= 4'd4;
            last_i <= 6'd43;
            wi     <= 6'd0;
            ph     <= 3'd0;
            rcon   <= 8'h01;
        end else if (start_ok) begin
            nk     <= nk_sel;
            last_i <= last_sel;
            wi     <= 6'd0;
            ph     <= 3'd0;
            rcon   <= 8'h01;
        end else if (advance) begin
            wi <= wi + 6'd1;
            ph <= (ph == ph_wrap) ? 3'd0 : ph + 3'd1;
            if (past_key && (ph == 3'd0)) begin
                rcon <= rcon_nxt;
            end
        end
    end

    // Latched key words, sliding window of recent words and the partial group.
    always_ff @(posedge clk) begin
        if (start_ok) begin
            for (int k = 0; k < 8; k++) begin
                key_w[k] <= key_in[32*(7-k) +: 32];
            end
        end
        if (advance) begin
            win[0] <= w_new;
            for (int k = 1; k < 8; k++) begin
                win[k] <= win[k-1];
            end
            grp <= {grp[63:0], w_new};
        end
    end

    // Round-key output register and the end-of-run pulse.
    always_ff @(posedge clk) begin
        if (rst) begin
            rk_out   <= 128'h0;
            rk_idx   <= 4'd0;
            rk_valid <= 1'b0;
            rk_last  <= 1'b0;
            done     <= 1'b0;
        end else begin
            done <= (state == DRAIN) && hs;
            if (load) begin
                rk_out   <= {grp, w_new};
                rk_idx   <= wi[5:2];
                rk_valid <= 1'b1;
                rk_last  <= last_word;
            end else if (hs) begin
                rk_valid <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_aes_key_expand.sv
// Directed bench for aes_key_expand with a scoreboard of expected round keys.
// Expected keys come from a behavioural key schedule using an algebraic
// (GF inverse + affine) S-box.

module tb_aes_key_expand;
    logic         clk = 1'b0;
    logic         rst;
    logic         start;
    logic         n_start;
    logic [1:0]   key_len;
    logic [255:0] key_in;
    logic [127:0] rk_out;
    logic [3:0]   rk_idx;
    logic         rk_valid;
    logic         rk_ready;
    logic         rk_last;
    logic         busy;
    logic         done;

    logic [127:0] n_rk_out;
    logic [3:0]   n_rk_idx;
    logic         n_rk_valid;
    logic         n_rk_last;
    logic         n_busy;
    logic         n_done;

    int tests  = 0;
    int failed = 0;

    typedef struct {
        logic [3:0]   idx;
        logic [127:0] rk;
        logic         last;
    } exp_t;

    exp_t         sb[$];
    logic [127:0] cap [15];

    localparam logic [255:0] K128 = {128'h2b7e151628aed2a6abf7158809cf4f3c, 128'h0};
    localparam logic [255:0] K192 = {192'h8e73b0f7da0e6452c810f32b809079e562f8ead2522c6b7b, 64'h0};
    localparam logic [255:0] K256 = 256'h603deb1015ca71be2b73aef0857d77811f352c073b6108d72d9810a30914dff4;

    aes_key_expand dut (
        .clk(clk), .rst(rst), .start(start), .key_len(key_len), .key_in(key_in),
        .rk_out(rk_out), .rk_idx(rk_idx), .rk_valid(rk_valid), .rk_ready(rk_ready),
        .rk_last(rk_last), .busy(busy), .done(done)
    );

    aes_key_expand #(.ENABLE_192(1'b0)) dut_n192 (
        .clk(clk), .rst(rst), .start(n_start), .key_len(key_len), .key_in(key_in),
        .rk_out(n_rk_out), .rk_idx(n_rk_idx), .rk_valid(n_rk_valid), .rk_ready(rk_ready),
        .rk_last(n_rk_last), .busy(n_busy), .done(n_done)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        tests++;
        assert (obs === exp) else begin
            failed++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        p = 8'h00;
        for (int k = 0; k < 8; k++) begin
            if (b[0]) p = p ^ a;
            a = {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
            b = b >> 1;
        end
        return p;
    endfunction

    function automatic logic [7:0] rotl8(input logic [7:0] b, input int n);
        return 8'((b << n) | (b >> (8 - n)));
    endfunction

    function automatic logic [7:0] sbox_f(input logic [7:0] x);
        logic [7:0] sq;
        logic [7:0] inv;
        sq  = x;
        inv = 8'h01;
        for (int k = 1; k < 8; k++) begin
            sq  = gmul(sq, sq);
            inv = gmul(inv, sq);
        end
        return inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
    endfunction

    function automatic logic [31:0] sub_word(input logic [31:0] v);
        return {sbox_f(v[31:24]), sbox_f(v[23:16]), sbox_f(v[15:8]), sbox_f(v[7:0])};
    endfunction

    // Behavioural key schedule; pushes every round key to the scoreboard.
    task automatic model_push(input logic [255:0] key, input logic [1:0] len);
        logic [31:0] w [60];
        logic [31:0] t;
        logic [7:0]  rc [10];
        int nk;
        int nr;
        exp_t e;
        rc = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80, 8'h1b, 8'h36};
        nk = (len == 2'b00) ? 4 : (len == 2'b01) ? 6 : 8;
        nr = nk + 6;
        for (int i = 0; i < 4 * (nr + 1); i++) begin
            if (i < nk) begin
                w[i] = key[255 - 32*i -: 32];
            end else begin
                t = w[i-1];
                if (i % nk == 0)
                    t = sub_word({t[23:0], t[31:24]}) ^ {rc[i/nk - 1], 24'h0};
                else if (nk > 6 && i % nk == 4)
                    t = sub_word(t);
                w[i] = w[i-nk] ^ t;
            end
        end
        for (int k = 0; k <= nr; k++) begin
            e.idx  = 4'(k);
            e.rk   = {w[4*k], w[4*k+1], w[4*k+2], w[4*k+3]};
            e.last = (k == nr);
            sb.push_back(e);
        end
    endtask

    task automatic run_key(input logic [255:0] key, input logic [1:0] len,
                           input bit bp, input int abort_idx);
        int   nr;
        int   n_keys;
        int   cyc;
        int   got;
        int   done_cnt;
        int   done_at;
        int   first_valid;
        bit   prev_stall;
        logic [127:0] h_out;
        logic [3:0]   h_idx;
        logic         h_last;
        exp_t e;

        nr = (len == 2'b00) ? 10 : (len == 2'b01) ? 12 : 14;
        n_keys = nr + 1;
        for (int k = 0; k < 15; k++) cap[k] = 'x;
        sb.delete();
        model_push(key, len);

        @(negedge clk);
        key_in   = key;
        key_len  = len;
        start    = 1'b1;
        n_start  = (len == 2'b01);
        rk_ready = 1'b1;

        cyc = -1; got = 0; done_cnt = 0; done_at = -1; first_valid = -1;
        prev_stall = 1'b0;
        h_out = '0; h_idx = '0; h_last = 1'b0;
        while (cyc < 600) begin
            @(negedge clk);
            cyc++;
            if (cyc == 0) begin
                start   = 1'b0;
                n_start = 1'b0;
                check("busy_after_start", busy, 1'b1);
            end
            if (len == 2'b01 && cyc == 10) start = 1'b1;
            if (len == 2'b01 && cyc == 11) start = 1'b0;
            if (len == 2'b01 && cyc == 6)
                check("n192_ignored", {n_rk_out, n_rk_idx, n_rk_valid, n_rk_last, n_busy, n_done}, '0);
            if (done) begin
                done_cnt++;
                done_at = cyc;
            end
            if (rk_valid && first_valid < 0) first_valid = cyc;
            if (prev_stall)
                check("stall_hold", {rk_valid, rk_out, rk_idx, rk_last}, {1'b1, h_out, h_idx, h_last});
            if (got == n_keys && !busy) break;

            rk_ready = bp ? 1'($urandom_range(0, 1)) : 1'b1;
            if (rk_valid && rk_ready) begin
                if (sb.size() == 0) begin
                    check("sb_underflow", sb.size(), 1);
                end else begin
                    e = sb.pop_front();
                    check("rk_idx", rk_idx, e.idx);
                    check("rk_out", rk_out, e.rk);
                    check("rk_last", rk_last, e.last);
                    if (!bp) check("hs_cycle", cyc, 4 + 4*got);
                    cap[rk_idx] = rk_out;
                    got++;
                    if (abort_idx == int'(e.idx)) begin
                        rst = 1'b1;
                        @(negedge clk);
                        rst = 1'b0;
                        check("abort_state", {rk_valid, busy, done, rk_out, rk_idx, rk_last}, '0);
                        sb.delete();
                        return;
                    end
                end
            end
            prev_stall = rk_valid && !rk_ready;
            h_out  = rk_out;
            h_idx  = rk_idx;
            h_last = rk_last;
        end

        check("keys_received", got, n_keys);
        check("sb_empty", sb.size(), 0);
        check("done_pulses", done_cnt, 1);
        if (!bp) begin
            check("first_valid_cycle", first_valid, 4);
            check("done_cycle", done_at, 4*(nr+1) + 1);
        end
        @(negedge clk);
        check("done_single", {done, rk_valid, busy}, 3'b000);
    endtask

    initial begin
        rst      = 1'b1;
        start    = 1'b0;
        n_start  = 1'b0;
        key_len  = 2'b00;
        key_in   = '0;
        rk_ready = 1'b0;
        repeat (2) @(negedge clk);
        check("reset_state", {rk_out, rk_idx, rk_valid, rk_last, busy, done}, '0);
        rst = 1'b0;

        run_key(K128, 2'b00, 1'b0, -1);
        check("k128_rk1", cap[1], 128'ha0fafe1788542cb123a339392a6c7605);
        check("k128_rk10", cap[10], 128'hd014f9a8c9ee2589e13f0cc8b6630ca6);

        run_key(K192, 2'b01, 1'b0, -1);
        check("k192_rk12", cap[12], 128'he98ba06f448c773c8ecc720401002202);

        run_key(K256, 2'b10, 1'b0, -1);
        check("k256_rk1", cap[1], 128'h1f352c073b6108d72d9810a30914dff4);
        check("k256_rk14", cap[14], 128'hfe4890d1e6188d0b046df344706c631e);

        @(negedge clk);
        key_in  = K128;
        key_len = 2'b11;
        start   = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int k = 0; k < 4; k++) begin
            check("reserved_len_idle", {busy, rk_valid}, 2'b00);
            @(negedge clk);
        end

        run_key(K128, 2'b00, 1'b1, -1);
        check("bp128_rk10", cap[10], 128'hd014f9a8c9ee2589e13f0cc8b6630ca6);
        run_key(K192, 2'b01, 1'b1, -1);
        check("bp192_rk12", cap[12], 128'he98ba06f448c773c8ecc720401002202);
        run_key(K256, 2'b10, 1'b1, -1);
        check("bp256_rk14", cap[14], 128'hfe4890d1e6188d0b046df344706c631e);

        run_key(K128, 2'b00, 1'b0, 5);
        run_key(K128, 2'b00, 1'b0, -1);
        check("rerun_rk1", cap[1], 128'ha0fafe1788542cb123a339392a6c7605);
        check("rerun_rk10", cap[10], 128'hd014f9a8c9ee2589e13f0cc8b6630ca6);

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end
endmodule
